keycode_fifo_pio: RTL and testbench
===================================

# keycode_fifo_pio

Parametrised Avalon-MM output port that buffers keycodes written by the Nios II processor in a FIFO and hands them to fabric logic over a valid/ready stream. It succeeds the single-register keycode PIO: instead of one overwrite-on-write byte, software can queue up to `FIFO_DEPTH` codes without losing any. It sits between the Nios system interconnect (s1 slave) and the chip-checker control logic. It also keeps a held `out_port` copy of the last code the consumer accepted.

## Interface
- `DATA_WIDTH`, 8: keycode width, 1..32.
- `FIFO_DEPTH`, 8: entries; power of 2, 2..256.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous assert, active-low reset. One clock; reset is asynchronous and active-low.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read data. Zero-read latency.
- `out_valid` out 1: FIFO not empty.
- `out_data` out `DATA_WIDTH`: FIFO head entry.
- `out_ready` in 1: consumer accepts the head.
- `out_port` out `DATA_WIDTH`: last popped code, held until the next pop.
- `irq` out 1: present only with `KEYCODE_FIFO_IRQ_EN`.

## Operation
- Write strobe: `wr = chipselect & ~write_n`.
- Address 0, write: push `writedata[DATA_WIDTH-1:0]`.
- Address 0, read: `out_port`, zero-extended.
- Address 1, read-only status:
  - `[15:0]` count.
  - bit16 empty.
  - bit17 full.
  - bit18 overflow (sticky).
  - all other bits 0.
- Address 2, write control:
  - bit0 = 1: flush.
  - bit1 = 1: clear overflow.
  - bit2: irq_mask, stored only with the macro.
- Address 2, read: bit2 = irq_mask; all other bits 0.
- Address 3: reads 0; writes ignored.
- FIFO storage:
  - Circular buffer with read and write pointers, each `$clog2(FIFO_DEPTH)` bits, wrapping modulo depth.
  - Count is `$clog2(FIFO_DEPTH)+1` bits.
- Pop: `out_valid & out_ready`.
  - Advance the read pointer.
  - `out_port <= out_data`.
- Push when not full: write at the write pointer; advance the pointer.
- Push when full: dropped; overflow set.
  - Full is evaluated on the registered state at the start of the cycle.
  - A push while full is dropped even if a pop occurs in the same cycle.
- Push and pop in the same cycle, not full and not empty: both happen; count unchanged.
- Push while empty with `out_ready` = 1: no pop that cycle, because `out_valid` is 0; the push is accepted.
- Flush:
  - Pointers and count go to 0.
  - Flush beats any same-cycle pop. `out_port` is not updated by a pop in a flush cycle.
  - `out_port` itself is not cleared.
- Overflow and clear in the same cycle: set wins; overflow stays 1.

## Timing
- Reset values:
  - `out_port` = 0, count = 0, pointers = 0.
  - `out_valid` = 0, overflow = 0, irq_mask = 0, `irq` = 0.
  - Storage contents are don't-care.
- `out_valid` and `out_data` are driven from registered state only.
- Write latency: a push at edge N gives `out_valid` = 1 after edge N when the FIFO was empty.
- Pop latency: `out_port` updates at the accepting edge. The next entry is presented the following cycle.
- `readdata` is combinational from `address` and the current registers. A read in the same cycle as a write returns the pre-write value.
- `out_ready` may be asserted without `out_valid`; this has no effect.
- Reset asserted mid-stream clears state immediately (asynchronous). There is no pop on the release edge.

## Configuration
- With `KEYCODE_FIFO_IRQ_EN` defined:
  - The irq_mask register exists.
  - `irq` is registered: `irq <= irq_mask & (empty | overflow)` on the next edge.
  - Software acknowledges by pushing (clears empty) or by clearing overflow.
- Without it:
  - No `irq` port.
  - bit2 of address 2 reads 0; writes to it are ignored.

## Test plan
Bench parameters: `DATA_WIDTH` = 8, `FIFO_DEPTH` = 4.
- Reset, then read address 1 -> 0x0001_0000. `out_port` = 0x00, `out_valid` = 0.
- Push 0x1C, 0x1D, 0x1E with `out_ready` = 0.
  - Status count = 3.
  - `out_data` = 0x1C.
  - Raise `out_ready` for 3 cycles -> `out_port` steps 0x1C, 0x1D, 0x1E; then `out_valid` = 0.
- Fill with 0xA0..0xA3, then push 0xA4 with `out_ready` = 1 in the same cycle.
  - 0xA4 is dropped; 0xA0 pops.
  - Status count = 3, overflow = 1 (0x0004_0003).
  - Write address 2 = 0x2 -> overflow cleared.
- Wrap check: push/pop 10 codes 0x00..0x09 one at a time -> pop order 0x00..0x09 exactly; pointers wrap; count never exceeds 1.
- Push 0x55, 0x66, then write address 2 = 0x1 with `out_ready` = 1 in the same cycle.
  - Count = 0, `out_valid` = 0.
  - `out_port` keeps its previous value.
- Macro on: write address 2 = 0x4 -> `irq` = 1 next cycle (empty). Push 0x33 -> `irq` = 0 one cycle after the empty flag clears. Drop `reset_n` mid-transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/keycode_fifo_pio.sv
// ---------------------------------------------------------------------------
// keycode_fifo_pio
//
// Purpose: Avalon-MM output port that queues keycodes written by the Nios II
// processor in a circular FIFO. The FIFO head is offered to fabric logic over
// a valid/ready stream. A held copy of the most recently accepted code is
// kept on out_port.
//
// Optional feature macro: KEYCODE_FIFO_IRQ_EN
//   When defined, the design adds an irq_mask register (address 2, bit 2) and
//   a registered irq output: irq = irq_mask & (empty | overflow).
//
// Parameters:
//   DATA_WIDTH  keycode width, 1..32
//   FIFO_DEPTH  number of entries, power of 2, 2..256
//
// Ports:
//   clk         single clock
//   reset_n     asynchronous, active-low reset
//   address     register select (0 data, 1 status, 2 control, 3 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit combinational read data (zero wait states)
//   out_valid   FIFO not empty
//   out_data    FIFO head entry (0 while empty)
//   out_ready   consumer accepts the head
//   out_port    last popped code, held until the next pop
//   irq         interrupt request (only with KEYCODE_FIFO_IRQ_EN)
//
// Stream handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1. out_valid/out_data depend only on registered state.
// out_ready may be high while out_valid is low; nothing happens then.
//
// Register map:
//   0 W  push writedata[DATA_WIDTH-1:0]     R  out_port, zero-extended
//   1 R  [15:0] count, [16] empty, [17] full, [18] overflow (sticky)
//   2 W  [0] flush, [1] clear overflow, [2] irq_mask
//     R  [2] irq_mask
//   3    reads 0, writes ignored
// ---------------------------------------------------------------------------
module keycode_fifo_pio #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_port
`ifdef KEYCODE_FIFO_IRQ_EN
   ,
   output logic                  irq
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_FULL    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
   localparam logic [PW-1:0] C_PTR_ONE = PW'(1);

   // Storage and state
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_out_port;
   logic                  r_overflow;

   // Decoded strobes
   logic          w_wr;
   logic          w_push_req;
   logic          w_ctrl_wr;
   logic          w_flush;
   logic          w_clr_ovf;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_ovf_set;
   logic [CW-1:0] w_count_nxt;
   logic [31:0]   w_status;
   logic          w_unused_wdata;

   assign w_wr       = chipselect & ~write_n;
   assign w_push_req = w_wr & (address == 2'd0);
   assign w_ctrl_wr  = w_wr & (address == 2'd2);
   assign w_flush    = w_ctrl_wr & writedata[0];
   assign w_clr_ovf  = w_ctrl_wr & writedata[1];

   // Full/empty come from the registered count only, so a push while full
   // is dropped even when a pop frees a slot in the same cycle.
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == C_FULL);
   assign w_push     = w_push_req & ~w_full;
   assign w_ovf_set  = w_push_req & w_full;

   // A flush cycle suppresses the pop so out_port keeps its value.
   assign w_pop      = out_valid & out_ready & ~w_flush;

   // Only a slice of writedata carries meaning; fold the rest into one
   // deliberately unused wire.
   assign w_unused_wdata = ^writedata;

   assign out_valid  = ~w_empty;
   assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
   assign out_port   = r_out_port;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + C_CNT_ONE;
         2'b01:   w_count_nxt = r_count - C_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage has no reset; contents behind the read pointer are don't-care.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= writedata[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_out_port <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count <= w_count_nxt;
         end
         if (w_pop) begin
            r_out_port <= out_data;
         end
         // Setting overflow wins over a same-cycle clear.
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

`ifdef KEYCODE_FIFO_IRQ_EN
   logic r_irq_mask;
   logic r_irq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_irq_mask <= writedata[2];
         end
         r_irq <= r_irq_mask & (w_empty | r_overflow);
      end
   end

   assign irq = r_irq;
`endif

   always_comb begin
      w_status            = '0;
      w_status[CW-1:0]    = r_count;
      w_status[16]        = w_empty;
      w_status[17]        = w_full;
      w_status[18]        = r_overflow;
   end

   // Zero-latency read: reflects registers before any same-cycle write.
   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = 32'(r_out_port);
         2'd1:    readdata = w_status;
         2'd2: begin
`ifdef KEYCODE_FIFO_IRQ_EN
            readdata[2] = r_irq_mask;
`else
            readdata = '0;
`endif
         end
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_keycode_fifo_pio.sv
// ---------------------------------------------------------------------------
// tb_keycode_fifo_pio
//
// Directed bench for keycode_fifo_pio with DATA_WIDTH = 8, FIFO_DEPTH = 4.
// Inputs change on the falling clock edge; outputs are sampled there too,
// half a cycle away from the rising edge that updates the design.
// Build with +define+KEYCODE_FIFO_IRQ_EN to also exercise the irq path.
// ---------------------------------------------------------------------------
module tb_keycode_fifo_pio;

   localparam int DW = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [DW-1:0] out_port;
`ifdef KEYCODE_FIFO_IRQ_EN
   logic          irq;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] rd;

   keycode_fifo_pio #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .out_port   (out_port)
`ifdef KEYCODE_FIFO_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One bus write occupying exactly one rising edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Zero-latency read, taken between rising edges.
   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      bus_read(2'd1, rd);  chk("reset_status", rd, 32'h0001_0000);
      bus_read(2'd0, rd);  chk("reset_rd_port", rd, 32'h0);
      chk("reset_out_port", {24'h0, out_port}, 32'h0);
      chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
`ifdef KEYCODE_FIFO_IRQ_EN
      chk("reset_irq", {31'h0, irq}, 32'h0);
`endif

      // Three pushes then three pops
      bus_write(2'd0, 32'h1C);
      bus_write(2'd0, 32'h1D);
      bus_write(2'd0, 32'h1E);
      bus_read(2'd1, rd);  chk("q3_status", rd, 32'h0000_0003);
      chk("q3_out_data", {24'h0, out_data}, 32'h1C);
      chk("q3_out_valid", {31'h0, out_valid}, 32'h1);
      out_ready = 1'b1;
      @(negedge clk);  chk("pop1_out_port", {24'h0, out_port}, 32'h1C);
      chk("pop1_out_data", {24'h0, out_data}, 32'h1D);
      @(negedge clk);  chk("pop2_out_port", {24'h0, out_port}, 32'h1D);
      @(negedge clk);  chk("pop3_out_port", {24'h0, out_port}, 32'h1E);
      out_ready = 1'b0;
      chk("drained_valid", {31'h0, out_valid}, 32'h0);
      bus_read(2'd1, rd);  chk("drained_status", rd, 32'h0001_0000);
      bus_read(2'd0, rd);  chk("rd_port_1E", rd, 32'h1E);

      // Fill, then push while full with a same-cycle pop
      for (int i = 0; i < 4; i++) bus_write(2'd0, 32'hA0 + i);
      bus_read(2'd1, rd);  chk("full_status", rd, 32'h0002_0004);
      @(negedge clk);
      address = 2'd0; writedata = 32'hA4; chipselect = 1'b1; write_n = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
      chk("ovf_out_port", {24'h0, out_port}, 32'hA0);
      chk("ovf_out_data", {24'h0, out_data}, 32'hA1);
      bus_read(2'd1, rd);  chk("ovf_status", rd, 32'h0004_0003);
      bus_write(2'd2, 32'h2);
      bus_read(2'd1, rd);  chk("ovf_clr_status", rd, 32'h0000_0003);
      out_ready = 1'b1;
      @(negedge clk);  chk("ovf_pop1", {24'h0, out_port}, 32'hA1);
      @(negedge clk);  chk("ovf_pop2", {24'h0, out_port}, 32'hA2);
      @(negedge clk);  chk("ovf_pop3", {24'h0, out_port}, 32'hA3);
      out_ready = 1'b0;
      chk("ovf_drained_valid", {31'h0, out_valid}, 32'h0);

      // Pointer wrap: one code at a time
      for (int i = 0; i < 10; i++) begin
         bus_write(2'd0, 32'(i));
         chk("wrap_valid", {31'h0, out_valid}, 32'h1);
         chk("wrap_out_data", {24'h0, out_data}, 32'(i));
         bus_read(2'd1, rd);  chk("wrap_status", rd, 32'h0000_0001);
         @(negedge clk);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("wrap_out_port", {24'h0, out_port}, 32'(i));
         chk("wrap_empty", {31'h0, out_valid}, 32'h0);
      end

      // Push into an empty FIFO with out_ready already high
      @(negedge clk);
      address = 2'd0; writedata = 32'h77; chipselect = 1'b1; write_n = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      chk("empty_push_valid", {31'h0, out_valid}, 32'h1);
      chk("empty_push_data", {24'h0, out_data}, 32'h77);
      chk("empty_push_port", {24'h0, out_port}, 32'h09);
      @(negedge clk);
      out_ready = 1'b0;
      chk("empty_push_popped", {24'h0, out_port}, 32'h77);

      // Flush with a same-cycle pop request
      bus_write(2'd0, 32'h55);
      bus_write(2'd0, 32'h66);
      @(negedge clk);
      address = 2'd2; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
      bus_read(2'd1, rd);  chk("flush_status", rd, 32'h0001_0000);
      chk("flush_valid", {31'h0, out_valid}, 32'h0);
      chk("flush_out_port", {24'h0, out_port}, 32'h77);

      // Reserved address
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_read(2'd3, rd);  chk("addr3_read", rd, 32'h0);
      bus_read(2'd1, rd);  chk("addr3_status", rd, 32'h0001_0000);

      // irq mask
      bus_write(2'd2, 32'h4);
      bus_read(2'd2, rd);
`ifdef KEYCODE_FIFO_IRQ_EN
      chk("mask_read", rd, 32'h4);
      chk("irq_before", {31'h0, irq}, 32'h0);
      @(negedge clk);
      chk("irq_empty", {31'h0, irq}, 32'h1);
`else
      chk("mask_read", rd, 32'h0);
`endif
      bus_write(2'd0, 32'h33);
`ifdef KEYCODE_FIFO_IRQ_EN
      chk("irq_after_push", {31'h0, irq}, 32'h1);
      @(negedge clk);
      chk("irq_ack", {31'h0, irq}, 32'h0);
`endif
      chk("pre_reset_valid", {31'h0, out_valid}, 32'h1);

      // Asynchronous reset mid-stream
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset_valid", {31'h0, out_valid}, 32'h0);
      chk("areset_out_data", {24'h0, out_data}, 32'h0);
      chk("areset_out_port", {24'h0, out_port}, 32'h0);
      bus_read(2'd1, rd);  chk("areset_status", rd, 32'h0001_0000);
      bus_read(2'd2, rd);  chk("areset_mask", rd, 32'h0);
`ifdef KEYCODE_FIFO_IRQ_EN
      chk("areset_irq", {31'h0, irq}, 32'h0);
`endif
      out_ready = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_out_port", {24'h0, out_port}, 32'h0);
      chk("release_valid", {31'h0, out_valid}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
